// File: rtl/axis_load_tg.sv
// axis_load_tg: AXI-Stream load generator for one mesh endpoint.
// Emits single-flit {timestamp, seq} packets to LFSR-chosen destinations.
module axis_load_tg #(
    parameter int unsigned SEED        = 2,
    parameter int          COUNT_WIDTH = 32,
    parameter int          TID         = 0,
    parameter int          TDATA_WIDTH = 64,
    parameter int          TDEST_WIDTH = 4,
    parameter int          TID_WIDTH   = 4,
    parameter int          NUM_ROUTERS = 16,
    parameter int          QUEUE_DEPTH = 16,
    parameter int          ALLOW_SELF  = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [15:0]                        load,
    input  logic [COUNT_WIDTH-1:0]             num_packets,
    input  logic                               start,
    input  logic [TDATA_WIDTH/2-1:0]           ticks,
    output logic                               done,
    output logic [NUM_ROUTERS*COUNT_WIDTH-1:0] sent_packets,
    output logic [COUNT_WIDTH-1:0]             total_sent_packets,
    output logic [COUNT_WIDTH-1:0]             stall_cycles,
    output logic                               axis_out_tvalid,
    input  logic                               axis_out_tready,
    output logic [TDATA_WIDTH-1:0]             axis_out_tdata,
    output logic                               axis_out_tlast,
    output logic [TID_WIDTH-1:0]               axis_out_tid,
    output logic [TDEST_WIDTH-1:0]             axis_out_tdest
);

    localparam int HW  = TDATA_WIDTH / 2;
    localparam int QAW = $clog2(QUEUE_DEPTH);
    localparam int EW  = TDEST_WIDTH + TDATA_WIDTH;

    localparam logic [31:0] SEED_W  = 32'(SEED);
    localparam logic [31:0] SEED2_W = 32'(SEED * 3 + 1);
    localparam logic [15:0] L1_SEED =
        (SEED_W[15:0] == 16'd0) ? 16'd1 : SEED_W[15:0];
    localparam logic [15:0] L2_SEED =
        (SEED2_W[15:0] == 16'd0) ? 16'd1 : SEED2_W[15:0];

    localparam logic [TDEST_WIDTH:0] NR   = (TDEST_WIDTH+1)'(NUM_ROUTERS);
    localparam logic [TDEST_WIDTH:0] SELF = (TDEST_WIDTH+1)'(TID);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    logic [1:0]             state_q, state_d;
    logic [15:0]            l1_q, l1_d;
    logic [15:0]            l2_q, l2_d;
    logic [COUNT_WIDTH-1:0] gen_q, gen_d;
    logic [COUNT_WIDTH-1:0] stall_q, stall_d;
    logic [COUNT_WIDTH-1:0] total_q, total_d;
    logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] sent_q, sent_d;
    logic [QAW:0]           wr_q, wr_d;
    logic [QAW:0]           rd_q, rd_d;
    logic                   ovalid_q, ovalid_d;
    logic [TDATA_WIDTH-1:0] odata_q, odata_d;
    logic [TDEST_WIDTH-1:0] odest_q, odest_d;
    logic [EW-1:0]          mem_q [QUEUE_DEPTH];

    logic                   running, remaining, attempt;
    logic                   q_empty, q_full, hs, pop, push, stall;
    logic [TDEST_WIDTH:0]   dest_ext;
    logic [EW-1:0]          entry;

    assign running   = (state_q == S_RUN);
    assign remaining = (gen_q != num_packets);
    assign attempt   = running && remaining && (l1_q <= load);
    assign q_empty   = (wr_q == rd_q);
    assign q_full    = (wr_q[QAW] != rd_q[QAW]) &&
                       (wr_q[QAW-1:0] == rd_q[QAW-1:0]);
    assign hs        = ovalid_q && axis_out_tready;
    // A pop on a full queue frees the slot the same-cycle push needs.
    assign pop       = !q_empty && (!ovalid_q || axis_out_tready);
    assign push      = attempt && (!q_full || pop);
    assign stall     = attempt && q_full && !pop;

    always_comb begin
        dest_ext = {1'b0, l2_q[TDEST_WIDTH-1:0]};
        if (dest_ext >= NR) dest_ext = dest_ext - NR;
        if (ALLOW_SELF == 0 && dest_ext == SELF) begin
            dest_ext = (dest_ext + 1'b1 == NR) ? '0 : dest_ext + 1'b1;
        end
    end

    assign entry = {dest_ext[TDEST_WIDTH-1:0], ticks, gen_q[HW-1:0]};

    always_comb begin
        state_d  = state_q;
        l1_d     = l1_q;
        l2_d     = l2_q;
        gen_d    = gen_q;
        stall_d  = stall_q;
        total_d  = total_q;
        sent_d   = sent_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        odest_d  = odest_q;

        if (running) l1_d = lfsr_step(l1_q);
        if (push) begin
            wr_d  = wr_q + 1'b1;
            l2_d  = lfsr_step(l2_q);
            gen_d = gen_q + 1'b1;
        end
        if (stall) stall_d = stall_q + 1'b1;

        if (pop) begin
            rd_d               = rd_q + 1'b1;
            ovalid_d           = 1'b1;
            {odest_d, odata_d} = mem_q[rd_q[QAW-1:0]];
        end else if (hs) begin
            ovalid_d = 1'b0;
        end

        if (hs) begin
            total_d = total_q + 1'b1;
            for (int i = 0; i < NUM_ROUTERS; i++) begin
                if (odest_q == TDEST_WIDTH'(i)) sent_d[i] = sent_q[i] + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    gen_d   = '0;
                    stall_d = '0;
                    total_d = '0;
                    sent_d  = '0;
                end
            end
            S_RUN:   if (!remaining) state_d = S_DRAIN;
            S_DRAIN: if (q_empty && !ovalid_q) state_d = S_DONE;
            S_DONE:  if (!start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            l1_q     <= L1_SEED;
            l2_q     <= L2_SEED;
            gen_q    <= '0;
            stall_q  <= '0;
            total_q  <= '0;
            sent_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            odest_q  <= '0;
        end else begin
            state_q  <= state_d;
            l1_q     <= l1_d;
            l2_q     <= l2_d;
            gen_q    <= gen_d;
            stall_q  <= stall_d;
            total_q  <= total_d;
            sent_q   <= sent_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            odest_q  <= odest_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[QAW-1:0]] <= entry;
    end

    assign done               = (state_q == S_DONE);
    assign sent_packets       = sent_q;
    assign total_sent_packets = total_q;
    assign stall_cycles       = stall_q;
    assign axis_out_tvalid    = ovalid_q;
    assign axis_out_tdata     = odata_q;
    assign axis_out_tlast     = ovalid_q;
    assign axis_out_tid       = TID_WIDTH'(TID);
    assign axis_out_tdest     = odest_q;

endmodule
